// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state and owner encodings for the memory port arbiter
package mem_arb_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: picks I or D for the next memory transaction
// ARB_ROUND_ROBIN_EN selects alternation on ties instead of fixed D>I priority
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_owner,
    output logic win_valid,
    output logic win_owner
);
    assign win_valid = i_req | d_req;
`ifdef ARB_ROUND_ROBIN_EN
    assign win_owner = (i_req & d_req) ? (last_owner == OWN_D ? OWN_I : OWN_D) : (d_req ? OWN_D : OWN_I);
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
    assign win_owner = d_req ? OWN_D : OWN_I;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (I) and load/store (D)
// ARB_ROUND_ROBIN_EN enables round-robin tie breaking in arb_pick
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_t state;
    logic owner, last_owner, win_valid, win_owner;
    arb_pick u_pick (
        .i_req     (i_req),
        .d_req     (d_req),
        .last_owner(last_owner),
        .win_valid (win_valid),
        .win_owner (win_owner)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            owner      <= OWN_I;
            last_owner <= OWN_D;
            i_gnt      <= 1'b0;
            d_gnt      <= 1'b0;
            i_rvalid   <= 1'b0;
            d_rvalid   <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            i_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            if (state == ST_IDLE && win_valid) begin
                state     <= ST_BUSY;
                owner     <= win_owner;
                mem_req   <= 1'b1;
                mem_we    <= (win_owner == OWN_D) & d_we;
                mem_addr  <= win_owner == OWN_D ? d_addr : i_addr;
                mem_wdata <= win_owner == OWN_D ? d_wdata : '0;
                i_gnt     <= win_owner == OWN_I;
                d_gnt     <= win_owner == OWN_D;
            end else if (state == ST_BUSY && mem_ack) begin
                state      <= ST_IDLE;
                mem_req    <= 1'b0;
                last_owner <= owner;
                if (owner == OWN_D) begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= mem_we ? '0 : mem_rdata;
                end else begin
                    i_rvalid <= 1'b1;
                    i_rdata  <= mem_rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus tie/reset sequences for mem_port_arbiter
module tb_mem_port_arbiter;
    logic clk = 0, reset = 0;
    logic i_req = 0, d_req = 0, d_we = 0, mem_ack = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
    logic i_gnt, i_rvalid, d_gnt, d_rvalid, mem_req, mem_we;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic ig, iv; logic [31:0] ird;
        logic dg, dv; logic [31:0] drd;
        logic mr, mwe; logic [31:0] ma, mwd;
    } out_t;
    typedef struct packed {
        logic rst, ir; logic [31:0] ia;
        logic dr, dwe; logic [31:0] da, dwd;
        logic ack; logic [31:0] mrd;
        out_t exp;
    } vec_t;

    vec_t v[12];
    out_t got;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] g, input logic [31:0] e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, g, e);
        end
    endtask

    task automatic drive(input logic rst, input logic ir, input logic [31:0] ia, input logic dr,
                         input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                         input logic ack, input logic [31:0] mrd);
        reset = rst; i_req = ir; i_addr = ia; d_req = dr; d_we = dwe;
        d_addr = da; d_wdata = dwd; mem_ack = ack; mem_rdata = mrd;
    endtask

    initial begin
        logic first_is_d;
        logic exp_d[4];
        logic seq[4];
        int n;
        // rst ir ia  dr dwe da dwd  ack mrd | ig iv ird  dg dv drd  mr mwe ma mwd
        v[0]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 32'h0,
                  '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0}};
        v[1]  = '{1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 32'h0,
                  '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h40,   32'h0}};
        v[2]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,    32'h0,        1'b1, 32'h2402000A,
                  '{1'b0, 1'b1, 32'h2402000A, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h40,   32'h0}};
        v[3]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 32'h0,
                  '{1'b0, 1'b0, 32'h2402000A, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h40,   32'h0}};
        v[4]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h1000, 32'hDEADBEEF, 1'b0, 32'h0,
                  '{1'b0, 1'b0, 32'h2402000A, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h1000, 32'hDEADBEEF}};
        v[5]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 32'h0,
                  '{1'b0, 1'b0, 32'h2402000A, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h1000, 32'hDEADBEEF}};
        v[6]  = v[5];
        v[7]  = v[5];
        v[8]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,    32'h0,        1'b1, 32'h12345678,
                  '{1'b0, 1'b0, 32'h2402000A, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 32'h1000, 32'hDEADBEEF}};
        v[9]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,    32'h0,        1'b1, 32'hFFFFFFFF,
                  '{1'b0, 1'b0, 32'h2402000A, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1000, 32'hDEADBEEF}};
        v[10] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h2000, 32'h0,        1'b0, 32'h0,
                  '{1'b0, 1'b0, 32'h2402000A, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h2000, 32'h0}};
        v[11] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,    32'h0,        1'b1, 32'hCAFEF00D,
                  '{1'b0, 1'b0, 32'h2402000A, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 32'h2000, 32'h0}};

        for (int k = 0; k < 12; k++) begin
            drive(v[k].rst, v[k].ir, v[k].ia, v[k].dr, v[k].dwe, v[k].da, v[k].dwd, v[k].ack, v[k].mrd);
            step();
            got = '{i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, mem_req, mem_we, mem_addr, mem_wdata};
            total++;
            if (got !== v[k].exp) begin
                bad++;
                $display("FAIL vec%0d: got %h want %h", k, got, v[k].exp);
            end
        end

        // reset in the second BUSY cycle abandons the transaction
        drive(0, 0, 0, 1, 0, 32'h3000, 0, 0, 0);
        step();
        chk("rst_gnt", {31'b0, d_gnt}, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("rst_busy2", {31'b0, mem_req}, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("rst_memreq", {30'b0, mem_req, d_rvalid}, 0);
        chk("rst_rdata", i_rdata | d_rdata, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h77);
        step();
        chk("idle_ack", {28'b0, mem_req, d_rvalid, i_gnt, d_gnt}, 0);
        drive(0, 1, 32'h44, 0, 0, 0, 0, 0, 0);
        step();
        chk("post_rst_gnt", {31'b0, i_gnt}, 1);
        chk("post_rst_addr", mem_addr, 32'h44);

        // tie with one request each: loser granted after completion plus one idle cycle
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
`ifdef ARB_ROUND_ROBIN_EN
        first_is_d = 1'b0;
`else
        first_is_d = 1'b1;
`endif
        drive(0, 1, 32'h80, 1, 0, 32'h90, 0, 0, 0);
        step();
        chk("tie_first", {30'b0, d_gnt, i_gnt}, first_is_d ? 2 : 1);
        chk("tie_first_addr", mem_addr, first_is_d ? 32'h90 : 32'h80);
        if (first_is_d) d_req = 0; else i_req = 0;
        mem_ack = 1; mem_rdata = 32'h5A5A;
        step();
        chk("tie_done", {28'b0, d_rvalid, i_rvalid, d_gnt | i_gnt, mem_req}, first_is_d ? 8 : 4);
        mem_ack = 0;
        step();
        chk("tie_second", {30'b0, d_gnt, i_gnt}, first_is_d ? 1 : 2);
        chk("tie_second_addr", mem_addr, first_is_d ? 32'h80 : 32'h90);
        i_req = 0; d_req = 0; mem_ack = 1;
        step();
        mem_ack = 0;

        // both held with immediate acks: four grants in order
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        for (int k = 0; k < 4; k++) exp_d[k] = first_is_d ? 1'b1 : k[0];
        drive(0, 1, 32'h100, 1, 0, 32'h200, 0, 1, 32'h9);
        n = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            step();
            if (i_gnt & d_gnt) chk("rr_double", 0, 1);
            if (i_gnt | d_gnt) begin
                seq[n] = d_gnt;
                n++;
            end
        end
        chk("rr_count", n, 4);
        for (int k = 0; k < n; k++) chk($sformatf("rr_grant%0d", k), {31'b0, seq[k]}, {31'b0, exp_d[k]});
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
